// File: rtl/sparc_decode_stage.sv
// SPARC V8 decode stage: one-entry holding register with valid/ready handshakes, RAW hazard
// detection against older stages, field split, and sethi-NOP bubble. Optional ID_FORWARD_EN adds forwarding.
module sparc_decode_stage #(
    parameter int          DATA_WIDTH = 32,
    parameter int          PC_WIDTH   = 64,
    parameter int          NUM_HAZ    = 3,
    parameter logic [31:0] NOP_INST   = 32'h01000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          if_valid,
    input  logic [31:0]                   if_inst,
    input  logic [PC_WIDTH-1:0]           if_pc4,
    output logic                          id_ready,
    input  logic                          flush,
    output logic [4:0]                    rf_rs1,
    output logic [4:0]                    rf_rs2,
    output logic [4:0]                    rf_rd,
    input  logic [DATA_WIDTH-1:0]         rf_val1,
    input  logic [DATA_WIDTH-1:0]         rf_val2,
    input  logic [DATA_WIDTH-1:0]         rf_val3,
    input  logic [NUM_HAZ*5-1:0]          haz_rd,
    input  logic [NUM_HAZ-1:0]            haz_wr,
    input  logic [NUM_HAZ*DATA_WIDTH-1:0] haz_data,
    input  logic [NUM_HAZ-1:0]            haz_fwd_ok,
    input  logic                          ex_ready,
    output logic                          id_valid,
    output logic [PC_WIDTH-1:0]           id_pc4,
    output logic [DATA_WIDTH-1:0]         valA,
    output logic [DATA_WIDTH-1:0]         valB,
    output logic [DATA_WIDTH-1:0]         valD,
    output logic [1:0]                    op,
    output logic [2:0]                    op2,
    output logic [5:0]                    op3,
    output logic [3:0]                    cond,
    output logic                          a,
    output logic                          i,
    output logic [4:0]                    rd,
    output logic [12:0]                   imm13,
    output logic [21:0]                   disp22,
    output logic [29:0]                   disp30
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                state_reg, state_next;
    logic [31:0]           inst_reg, inst_next;
    logic [PC_WIDTH-1:0]   pc_reg, pc_next;

    logic                  held, stall, fire, capturable;
    logic                  use_rs1, use_rs2, use_rd;
    logic [NUM_HAZ-1:0]    hit1, hit2, hit3;
    logic [DATA_WIDTH-1:0] opnd1, opnd2, opnd3;

    // Register addresses come from the held word even while stalled, so late WB writes are seen.
    assign rf_rs1 = inst_reg[18:14];
    assign rf_rs2 = inst_reg[4:0];
    assign rf_rd  = inst_reg[29:25];

    // Format 1/2 use no sources; rs2 only for register form; rd only for stores (op3[2] = bit 21).
    assign use_rs1 = inst_reg[31];
    assign use_rs2 = inst_reg[31] & ~inst_reg[13];
    assign use_rd  = (inst_reg[31:30] == 2'b11) & inst_reg[21];

    generate
        for (genvar gi = 0; gi < NUM_HAZ; gi++) begin : g_haz
            logic [4:0] hrd;
            logic       live;
            assign hrd       = haz_rd[gi*5 +: 5];
            assign live      = haz_wr[gi] & (hrd != 5'd0);
            assign hit1[gi]  = live & use_rs1 & (hrd == rf_rs1);
            assign hit2[gi]  = live & use_rs2 & (hrd == rf_rs2);
            assign hit3[gi]  = live & use_rd  & (hrd == rf_rd);
        end
    endgenerate

`ifdef ID_FORWARD_EN
    logic blk1, blk2, blk3;

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        opnd1 = rf_val1;
        opnd2 = rf_val2;
        opnd3 = rf_val3;
        blk1  = 1'b0;
        blk2  = 1'b0;
        blk3  = 1'b0;
        for (int k = NUM_HAZ - 1; k >= 0; k--) begin
            if (hit1[k]) begin
                opnd1 = haz_data[k*DATA_WIDTH +: DATA_WIDTH];
                blk1  = ~haz_fwd_ok[k];
            end
            if (hit2[k]) begin
                opnd2 = haz_data[k*DATA_WIDTH +: DATA_WIDTH];
                blk2  = ~haz_fwd_ok[k];
            end
            if (hit3[k]) begin
                opnd3 = haz_data[k*DATA_WIDTH +: DATA_WIDTH];
                blk3  = ~haz_fwd_ok[k];
            end
        end
    end

    assign stall = blk1 | blk2 | blk3;
`else
    logic unused_fwd;

    assign opnd1      = rf_val1;
    assign opnd2      = rf_val2;
    assign opnd3      = rf_val3;
    assign stall      = |{hit1, hit2, hit3};
    assign unused_fwd = ^{haz_data, haz_fwd_ok};
`endif

    assign held       = (state_reg == HELD);
    assign id_valid   = held & ~flush & ~stall;
    assign fire       = id_valid & ex_ready;
    assign id_ready   = ~held | fire;
    assign capturable = if_valid & (if_inst != NOP_INST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            inst_reg  <= NOP_INST;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            inst_reg  <= inst_next;
            pc_reg    <= pc_next;
        end
    end

    // An empty slot always holds NOP_INST so the register addresses idle at %g0.
    always_comb begin
        state_next = state_reg;
        inst_next  = inst_reg;
        pc_next    = pc_reg;
        if (flush) begin
            state_next = EMPTY;
            inst_next  = NOP_INST;
            pc_next    = '0;
        end else if (~held | fire) begin
            if (capturable) begin
                state_next = HELD;
                inst_next  = if_inst;
                pc_next    = if_pc4;
            end else begin
                state_next = EMPTY;
                inst_next  = NOP_INST;
                pc_next    = '0;
            end
        end
    end

    assign id_pc4 = id_valid ? pc_reg : '0;
    assign valA   = (id_valid && rf_rs1 != 5'd0) ? opnd1 : '0;
    assign valB   = (id_valid && rf_rs2 != 5'd0) ? opnd2 : '0;
    assign valD   = (id_valid && rf_rd  != 5'd0) ? opnd3 : '0;
    assign op     = id_valid ? inst_reg[31:30] : 2'b00;
    assign op2    = id_valid ? inst_reg[24:22] : 3'b100;
    assign op3    = id_valid ? inst_reg[24:19] : 6'd0;
    assign cond   = id_valid ? inst_reg[28:25] : 4'd0;
    assign a      = id_valid & inst_reg[29];
    assign i      = id_valid & inst_reg[13];
    assign rd     = id_valid ? inst_reg[29:25] : 5'd0;
    assign imm13  = id_valid ? inst_reg[12:0]  : 13'd0;
    assign disp22 = id_valid ? inst_reg[21:0]  : 22'd0;
    assign disp30 = id_valid ? inst_reg[29:0]  : 30'd0;

endmodule

// File: tb/tb_sparc_decode_stage.sv
// Bench for sparc_decode_stage: directed scenarios plus randomized traffic against a
// one-slot queue model that decodes instructions from bit-field arithmetic.
module tb_sparc_decode_stage;

    localparam int          DW  = 32;
    localparam int          PW  = 64;
    localparam int          NH  = 3;
    localparam logic [31:0] NOP = 32'h01000000;
    localparam logic [31:0] ADD = 32'h8A00C004;   // add %r3,%r4,%r5
    localparam logic [31:0] SUB = 32'h8A20C004;   // sub %r3,%r4,%r5
    localparam logic [31:0] IMM = 32'h84006007;   // add %r1,7,%r2
    localparam logic [31:0] STD = 32'hD2386000;   // std %r9,[%r1+0]

    logic            clk = 1'b0;
    logic            reset, if_valid, flush, ex_ready;
    logic [31:0]     if_inst;
    logic [PW-1:0]   if_pc4;
    logic            id_ready, id_valid;
    logic [4:0]      rf_rs1, rf_rs2, rf_rd;
    logic [DW-1:0]   rf_val1, rf_val2, rf_val3;
    logic [NH*5-1:0] haz_rd;
    logic [NH-1:0]   haz_wr, haz_fwd_ok;
    logic [NH*DW-1:0] haz_data;
    logic [PW-1:0]   id_pc4;
    logic [DW-1:0]   valA, valB, valD;
    logic [1:0]      op;
    logic [2:0]      op2;
    logic [5:0]      op3;
    logic [3:0]      cond;
    logic            a, i_f;
    logic [4:0]      rd;
    logic [12:0]     imm13;
    logic [21:0]     disp22;
    logic [29:0]     disp30;

    logic [31:0]     regs [32];
    logic [263:0]    obs;

    // model: queue of at most one held {inst, pc4}
    logic [95:0]     slot_q [$];
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    assign rf_val1 = regs[rf_rs1];
    assign rf_val2 = regs[rf_rs2];
    assign rf_val3 = regs[rf_rd];
    assign obs = {id_valid, id_ready, rf_rs1, rf_rs2, rf_rd, id_pc4, valA, valB, valD,
                  op, op2, op3, cond, a, i_f, rd, imm13, disp22, disp30};

    sparc_decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
        .id_ready(id_ready), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_val1(rf_val1), .rf_val2(rf_val2), .rf_val3(rf_val3), .haz_rd(haz_rd),
        .haz_wr(haz_wr), .haz_data(haz_data), .haz_fwd_ok(haz_fwd_ok), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc4(id_pc4), .valA(valA), .valB(valB), .valD(valD),
        .op(op), .op2(op2), .op3(op3), .cond(cond), .a(a), .i(i_f), .rd(rd), .imm13(imm13),
        .disp22(disp22), .disp30(disp30)
    );

    function automatic logic [263:0] model_out();
        logic [31:0] x;
        logic [63:0] pc;
        int          opv, op3v, hr;
        int          src [3];
        bit          used [3];
        logic [31:0] v [3];
        bit          stall, valid, ready, full;
        full = (slot_q.size() != 0);
        x    = full ? slot_q[0][95:64] : NOP;
        pc   = full ? slot_q[0][63:0] : 64'd0;
        opv  = int'(x >> 30);
        op3v = int'((x >> 19) & 32'h3f);
        src[0] = int'((x >> 14) & 31);
        src[1] = int'(x & 31);
        src[2] = int'((x >> 25) & 31);
        used[0] = (opv >= 2);
        used[1] = (opv >= 2) && (((x >> 13) & 1) == 0);
        used[2] = (opv == 3) && ((op3v & 4) != 0);
        stall = 0;
        for (int s = 0; s < 3; s++) begin
            v[s] = (src[s] == 0) ? 32'd0 : regs[src[s]];
            if (used[s]) begin
                for (int k = 0; k < NH; k++) begin
                    hr = int'(haz_rd[k*5 +: 5]);
                    if (haz_wr[k] && hr != 0 && hr == src[s]) begin
`ifdef ID_FORWARD_EN
                        if (haz_fwd_ok[k]) v[s] = haz_data[k*DW +: DW];
                        else stall = 1;
`else
                        stall = 1;
`endif
                        break;
                    end
                end
            end
        end
        valid = full && !flush && !stall;
        ready = !full || (valid && ex_ready);
        if (valid)
            return {1'b1, ready, 5'(src[0]), 5'(src[1]), 5'(src[2]), pc, v[0], v[1], v[2],
                    2'(opv), 3'(x >> 22), 6'(op3v), 4'(x >> 25), 1'(x >> 29), 1'(x >> 13),
                    5'(src[2]), 13'(x), 22'(x), 30'(x)};
        return {1'b0, ready, 5'(src[0]), 5'(src[1]), 5'(src[2]), 64'd0, 96'd0, 2'd0, 3'b100,
                6'd0, 4'd0, 1'b0, 1'b0, 5'd0, 13'd0, 22'd0, 30'd0};
    endfunction

    task automatic tick();
        logic [263:0] e;
        e = model_out();
        @(posedge clk);
        if (reset || flush) begin
            slot_q.delete();
        end else if (slot_q.size() == 0 || (e[263] && ex_ready)) begin
            if (e[263] && ex_ready)
                $display("xact inst=%08h pc4=%016h", slot_q[0][95:64], slot_q[0][63:0]);
            slot_q.delete();
            if (if_valid && if_inst != NOP) slot_q.push_back({if_inst, if_pc4});
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; flush = 0; if_valid = 0; if_inst = NOP; if_pc4 = '0;
        ex_ready = 1; haz_wr = '0; haz_rd = '0; haz_fwd_ok = '0; haz_data = '0;
    endtask

    task automatic test_reset();
        logic [263:0] rv;
        rv = {1'b0, 1'b1, 15'd0, 64'd0, 96'd0, 2'd0, 3'b100, 6'd0, 4'd0, 1'b0, 1'b0,
              5'd0, 13'd0, 22'd0, 30'd0};
        idle();
        reset = 1; if_valid = 1; if_inst = ADD;
        tick(); tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if (obs !== rv) begin n_bad++; $display("FAIL reset_outputs got=%h want=%h", obs, rv); end
        n_cmp++;
        if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", id_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        regs[3] = 32'h1111_0003; regs[4] = 32'h2222_0004; regs[5] = 32'h5555_0005;
        if_valid = 1; if_inst = ADD; if_pc4 = 64'h1004;
        @(negedge clk);
        n_cmp++;
        if (id_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got=%b want=0", id_valid); end
        tick();
        if_inst = SUB; if_pc4 = 64'h1008;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, op, op3, rd, valA, valB, id_pc4} !== {1'b1, 2'b10, 6'd0, 5'd5, regs[3], regs[4], 64'h1004}) begin
            n_bad++; $display("FAIL b2b_add got v=%b op3=%h rd=%0d A=%h B=%h pc=%h want add fields",
                              id_valid, op3, rd, valA, valB, id_pc4);
        end
        tick();
        if_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, op3, id_pc4} !== {1'b1, 6'd4, 64'h1008}) begin
            n_bad++; $display("FAIL b2b_sub got v=%b op3=%h pc=%h want 1/04/1008", id_valid, op3, id_pc4);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (obs !== model_out()) begin n_bad++; $display("FAIL b2b_drain got=%h want=%h", obs, model_out()); end
        tick();
    endtask

    task automatic test_hazard_stall();
        idle();
        regs[3] = 32'h3333_3333;
        if_valid = 1; if_inst = ADD; if_pc4 = 64'h2004;
        tick();
        if_valid = 0;
        haz_rd = {5'd0, 5'd3, 5'd0}; haz_wr = 3'b010; haz_fwd_ok = 3'b010;
        haz_data = {32'd0, 32'hCAFE_0001, 32'd0};
`ifdef ID_FORWARD_EN
        @(negedge clk);
        n_cmp++;
        if ({id_valid, valA} !== {1'b1, 32'hCAFE_0001}) begin
            n_bad++; $display("FAIL haz_fwd got v=%b A=%h want 1/cafe0001", id_valid, valA);
        end
        tick();
`else
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({id_valid, id_ready} !== 2'b00) begin
                n_bad++; $display("FAIL haz_stall%0d got v=%b r=%b want 0/0", c, id_valid, id_ready);
            end
            tick();
        end
        haz_wr = '0;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, valA} !== {1'b1, regs[3]}) begin
            n_bad++; $display("FAIL haz_release got v=%b A=%h want 1/%h", id_valid, valA, regs[3]);
        end
        tick();
`endif
    endtask

    task automatic test_imm_store();
        idle();
        regs[1] = 32'h0101_0101; regs[9] = 32'h0909_0909;
        if_valid = 1; if_inst = IMM; if_pc4 = 64'h3004;
        haz_rd = {5'd0, 5'd0, 5'd7}; haz_wr = 3'b001;
        tick();
        if_inst = STD; if_pc4 = 64'h3008;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, i_f, imm13, valA} !== {1'b1, 1'b1, 13'd7, regs[1]}) begin
            n_bad++; $display("FAIL imm_nostall got v=%b i=%b imm=%0d A=%h want 1/1/7/%h",
                              id_valid, i_f, imm13, valA, regs[1]);
        end
        tick();
        if_valid = 0;
        haz_rd = {5'd9, 5'd0, 5'd0}; haz_wr = 3'b100; haz_fwd_ok = 3'b000;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, id_ready} !== 2'b00) begin
            n_bad++; $display("FAIL std_stall got v=%b r=%b want 0/0", id_valid, id_ready);
        end
        tick();
        haz_wr = '0;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, valD, rd} !== {1'b1, regs[9], 5'd9}) begin
            n_bad++; $display("FAIL std_release got v=%b D=%h rd=%0d want 1/%h/9", id_valid, valD, rd, regs[9]);
        end
        tick();
    endtask

    task automatic test_ex_stall();
        idle();
        if_valid = 1; if_inst = ADD; if_pc4 = 64'h4004;
        tick();
        ex_ready = 0; if_inst = SUB; if_pc4 = 64'h4008;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({id_valid, id_ready, op3, id_pc4} !== {2'b10, 6'd0, 64'h4004}) begin
                n_bad++; $display("FAIL exstall%0d got v=%b r=%b op3=%h pc=%h want 1/0/00/4004",
                                  c, id_valid, id_ready, op3, id_pc4);
            end
            tick();
        end
        ex_ready = 1; if_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, op3, id_pc4} !== {1'b1, 6'd0, 64'h4004}) begin
            n_bad++; $display("FAIL exstall_keep got v=%b op3=%h pc=%h want 1/00/4004", id_valid, op3, id_pc4);
        end
        tick();
    endtask

    task automatic test_flush_nop();
        idle();
        if_valid = 1; if_inst = ADD; if_pc4 = 64'h5004;
        tick();
        flush = 1; if_inst = SUB; if_pc4 = 64'h5008;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, id_ready, op2} !== {2'b00, 3'b100}) begin
            n_bad++; $display("FAIL flush_cycle got v=%b r=%b op2=%b want 0/0/100", id_valid, id_ready, op2);
        end
        tick();
        flush = 0; if_inst = NOP; if_pc4 = 64'h500C;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, id_ready, id_pc4} !== {2'b01, 64'd0}) begin
            n_bad++; $display("FAIL flush_empty got v=%b r=%b pc=%h want 0/1/0", id_valid, id_ready, id_pc4);
        end
        tick();
        if_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({id_valid, id_ready} !== 2'b01) begin
            n_bad++; $display("FAIL nop_not_captured got v=%b r=%b want 0/1", id_valid, id_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] x;
        idle();
        for (int c = 0; c < 3000; c++) begin
            x = $urandom;
            x[18:14] = 5'($urandom_range(0, 7));
            x[4:0]   = 5'($urandom_range(0, 7));
            x[29:25] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) x = NOP;
            if_inst  = x;
            if_pc4   = {$urandom, $urandom};
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NH; k++) begin
                haz_rd[k*5 +: 5]    = 5'($urandom_range(0, 7));
                haz_data[k*DW +: DW] = $urandom;
            end
            haz_wr     = NH'($urandom);
            haz_fwd_ok = NH'($urandom);
            regs[$urandom_range(0, 31)] = $urandom;
            @(negedge clk);
            n_cmp++;
            if (obs !== model_out()) begin
                n_bad++; $display("FAIL rand%0d got=%h want=%h", c, obs, model_out());
            end
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_hazard_stall();
        test_imm_store();
        test_ex_stall();
        test_flush_nop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
